// File: rtl/ram_banked_ctrl.sv
// Banked single-port RAM with valid/ready access, registered read data and a
// clear sequencer that zeroes one row of every bank per cycle after reset or on wipe.
module ram_banked_ctrl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned BANK_BITS = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wipe,
    output logic              ready,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              rvalid
);
    localparam int unsigned ROW_W = ADDR_W - BANK_BITS;
    localparam int unsigned ROWS  = 1 << ROW_W;
    localparam int unsigned BANKS = 1 << BANK_BITS;

    typedef enum logic {StSweep, StIdle} state_e;

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] mem_q [BANKS][ROWS];

    logic [BANK_BITS-1:0] bank;
    logic [ROW_W-1:0]     row;
    logic [ROW_W-1:0]     wr_row;
    logic [DATA_W-1:0]    wr_data;
    logic [BANKS-1:0]     bank_we;
    logic                 accept;

    assign bank   = addr[ADDR_W-1 -: BANK_BITS];
    assign row    = addr[ROW_W-1:0];
    assign accept = req & ready;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StSweep;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The row counter wraps to zero on the last sweep row by plain overflow.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StSweep: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (wipe) begin
                    state_d = StSweep;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StSweep;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ready = (state_q == StIdle);
        busy  = (state_q == StSweep);
    end

    always_comb begin
        data_out_d = data_out_q;
        rvalid_d   = 1'b0;
        if (accept && !rw) begin
            data_out_d = mem_q[bank][row];
            rvalid_d   = 1'b1;
        end
    end

    // The sweep forces every bank enable on and steers the row/data muxes.
    always_comb begin
        wr_row  = busy ? cnt_q : row;
        wr_data = busy ? '0 : data_in;
        for (int unsigned b = 0; b < BANKS; b++) begin
            bank_we[b] = busy || (accept && rw && (bank == BANK_BITS'(b)));
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < BANKS; b++) begin
            if (bank_we[b]) begin
                mem_q[b][wr_row] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            data_out_q <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign data_out = data_out_q;
    assign rvalid   = rvalid_q;

endmodule

// File: tb/tb_ram_banked_ctrl.sv
// Bench for ram_banked_ctrl: a word-level memory model checked every cycle on the
// default instance, plus directed literal checks on both default and wide instances.
module tb_ram_banked_ctrl;
    logic clk = 1'b0;
    logic clr = 1'b0;

    logic       req_a = 1'b0, rw_a = 1'b0, wipe_a = 1'b0;
    logic [3:0] addr_a = '0;
    logic [7:0] din_a = '0;
    logic       ready_a, busy_a, rvalid_a;
    logic [7:0] dout_a;

    logic        req_b = 1'b0, rw_b = 1'b0, wipe_b = 1'b0;
    logic [5:0]  addr_b = '0;
    logic [15:0] din_b = '0;
    logic        ready_b, busy_b, rvalid_b;
    logic [15:0] dout_b;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    ram_banked_ctrl u_dut_a (
        .clk(clk), .clr(clr), .req(req_a), .rw(rw_a), .addr(addr_a), .data_in(din_a),
        .wipe(wipe_a), .ready(ready_a), .busy(busy_a), .data_out(dout_a), .rvalid(rvalid_a)
    );

    ram_banked_ctrl #(.DATA_W(16), .ADDR_W(6), .BANK_BITS(3)) u_dut_b (
        .clk(clk), .clr(clr), .req(req_b), .rw(rw_b), .addr(addr_b), .data_in(din_b),
        .wipe(wipe_b), .ready(ready_b), .busy(busy_b), .data_out(dout_b), .rvalid(rvalid_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Word-level model: a sweep is just "4 busy edges, then all words are zero".
    int         sweep_left = 4;
    logic [7:0] m_mem [16];
    logic [7:0] m_dout = '0;
    logic       m_rv = 1'b0;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            sweep_left <= 4;
            m_dout     <= '0;
            m_rv       <= 1'b0;
        end else if (sweep_left > 0) begin
            m_rv       <= 1'b0;
            sweep_left <= sweep_left - 1;
            if (sweep_left == 1) begin
                foreach (m_mem[i]) m_mem[i] <= '0;
            end
        end else begin
            m_rv <= 1'b0;
            if (req_a) begin
                if (rw_a) begin
                    m_mem[addr_a] <= din_a;
                end else begin
                    m_dout <= m_mem[addr_a];
                    m_rv   <= 1'b1;
                end
            end
            if (wipe_a) sweep_left <= 4;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busy", busy_a, sweep_left > 0);
            chk("model_ready", ready_a, sweep_left == 0);
            chk("model_rvalid", rvalid_a, m_rv);
            chk("model_dout", dout_a, m_dout);
        end
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        req_a = 1'b1; rw_a = 1'b1; addr_a = a; din_a = d;
        @(negedge clk);
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] e, input string nm);
        req_a = 1'b1; rw_a = 1'b0; addr_a = a;
        @(negedge clk);
        chk({nm, "_rv"}, rvalid_a, 1'b1);
        chk(nm, dout_a, e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && busy_a; i++) @(negedge clk);
        chk("idle_timeout", busy_a, 1'b0);
    endtask

    task automatic count_busy(input string nm, input int exp);
        int n = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy_a) n++;
            @(negedge clk);
        end
        chk(nm, n, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int na, nb;
        logic rv_busy;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 1'b1);
        chk("rst_ready", ready_a, 1'b0);
        chk("rst_dout_b", dout_b, 16'h0);
        clr = 1'b1;

        na = 0; nb = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy_a) na++;
            if (busy_b) nb++;
            @(negedge clk);
        end
        chk("sweep_len_a", na, 4);
        chk("sweep_len_b", nb, 8);
        chk("b_ready", ready_b, 1'b1);

        // Wide instance: bank 5 row 2 written, bank 4 row 2 must stay clear.
        req_b = 1'b1; rw_b = 1'b1; addr_b = 6'h2A; din_b = 16'hBEEF;
        @(negedge clk);
        rw_b = 1'b0;
        @(negedge clk);
        chk("b_rd_2a_rv", rvalid_b, 1'b1);
        chk("b_rd_2a", dout_b, 16'hBEEF);
        addr_b = 6'h22;
        @(negedge clk);
        chk("b_rd_22_rv", rvalid_b, 1'b1);
        chk("b_rd_22", dout_b, 16'h0000);
        req_b = 1'b0;

        wr(4'h3, 8'hA5); wr(4'h7, 8'h5A); wr(4'hB, 8'hC3); wr(4'hF, 8'h3C);
        rd(4'h3, 8'hA5, "iso_3"); rd(4'h7, 8'h5A, "iso_7");
        rd(4'hB, 8'hC3, "iso_b"); rd(4'hF, 8'h3C, "iso_f");
        rd(4'h0, 8'h00, "iso_0"); rd(4'h4, 8'h00, "iso_4");
        rd(4'h8, 8'h00, "iso_8"); rd(4'hC, 8'h00, "iso_c");

        wr(4'h2, 8'h11);
        rd(4'h2, 8'h11, "lat_2");
        req_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_dout", dout_a, 8'h11);
            chk("hold_rv", rvalid_a, 1'b0);
        end

        for (int i = 0; i < 16; i++) wr(4'(i), 8'hFF);
        req_a = 1'b0; wipe_a = 1'b1;
        @(negedge clk);
        wipe_a = 1'b0; req_a = 1'b1; rw_a = 1'b0; addr_a = 4'h0;
        na = 0; rv_busy = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (busy_a) begin
                na++;
                if (rvalid_a) rv_busy = 1'b1;
            end
            @(negedge clk);
        end
        chk("wipe_len", na, 4);
        chk("wipe_no_rv", rv_busy, 1'b0);
        for (int i = 0; i < 16; i++) rd(4'(i), 8'h00, "wipe_rd");
        req_a = 1'b0;
        @(negedge clk);

        wr(4'h5, 8'h77);
        req_a = 1'b1; rw_a = 1'b0; addr_a = 4'h5; wipe_a = 1'b1;
        @(negedge clk);
        chk("simul_rv", rvalid_a, 1'b1);
        chk("simul_dout", dout_a, 8'h77);
        chk("simul_busy", busy_a, 1'b1);
        req_a = 1'b0; wipe_a = 1'b0;
        wait_idle();
        rd(4'h5, 8'h00, "simul_after");

        wr(4'h9, 8'h42);
        req_a = 1'b1; rw_a = 1'b0; addr_a = 4'h9; wipe_a = 1'b1;
        @(negedge clk);
        chk("mid_rd", dout_a, 8'h42);
        req_a = 1'b0; wipe_a = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy_pre", busy_a, 1'b1);
        #2 clr = 1'b0;
        #1;
        chk("mid_rst_busy", busy_a, 1'b1);
        chk("mid_rst_ready", ready_a, 1'b0);
        chk("mid_rst_rv", rvalid_a, 1'b0);
        chk("mid_rst_dout", dout_a, 8'h00);
        @(negedge clk);
        clr = 1'b1;
        count_busy("mid_sweep_len", 4);
        for (int i = 0; i < 16; i++) rd(4'(i), 8'h00, "mid_rd_all");
        req_a = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
